// File: rtl/commit_id_alloc.sv
// Dual-lane commit-ID allocator: hands out up to two free IDs per cycle from a 2^ID_WIDTH pool,
// stamps issued instructions with a running timestamp, and reclaims IDs from two commit ports.
module commit_id_alloc #(
    parameter int unsigned ID_WIDTH = 3,
    parameter int unsigned TS_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst1_req_i,
    input  logic                inst2_req_i,
    input  logic                hold_i,
    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic                commit_valid2_i,
    input  logic [ID_WIDTH-1:0] commit_id2_i,
    output logic                inst1_gnt_o,
    output logic                inst2_gnt_o,
    output logic [ID_WIDTH-1:0] inst1_commit_id_o,
    output logic [ID_WIDTH-1:0] inst2_commit_id_o,
    output logic [TS_WIDTH-1:0] inst1_timestamp_o,
    output logic [TS_WIDTH-1:0] inst2_timestamp_o,
    output logic                issue_stall_o,
    output logic [ID_WIDTH:0]   free_cnt_o,
    output logic                release_err_o
);

    localparam int unsigned N  = 1 << ID_WIDTH;
    localparam int unsigned CW = ID_WIDTH + 1;

    logic [N-1:0]        busy_q, busy_d;
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [CW-1:0]       free_q, free_d;
    logic                err_q, err_d;

    logic [ID_WIDTH-1:0] id_a, id_b, id2;
    logic                found_a, found_b;
    logic                have_one, have_two;
    logic                gnt1, gnt2;
    logic [N-1:0]        alloc_mask, rel_mask;
    logic                err_set;

    function automatic logic [CW-1:0] popcount(input logic [N-1:0] m);
        logic [CW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + CW'(m[i]);
        end
        return cnt;
    endfunction

    // Lowest and second-lowest free IDs, taken from the registered bitmap only.
    always_comb begin
        id_a    = '0;
        id_b    = '0;
        found_a = 1'b0;
        found_b = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!busy_q[i]) begin
                if (!found_a) begin
                    found_a = 1'b1;
                    id_a    = ID_WIDTH'(i);
                end else if (!found_b) begin
                    found_b = 1'b1;
                    id_b    = ID_WIDTH'(i);
                end
            end
        end
    end

    always_comb begin
        have_one = (free_q != '0);
        have_two = (free_q >= CW'(2));
        gnt1     = ~rst & inst1_req_i & ~hold_i & have_one;
        // Lane 2 only issues behind a granted lane 1 (in-order), or alone.
        if (inst1_req_i) begin
            gnt2 = ~rst & inst2_req_i & ~hold_i & have_two & gnt1;
        end else begin
            gnt2 = ~rst & inst2_req_i & ~hold_i & have_one;
        end
        id2 = inst1_req_i ? id_b : id_a;
    end

    always_comb begin
        alloc_mask = '0;
        rel_mask   = '0;
        if (gnt1) begin
            alloc_mask[id_a] = 1'b1;
        end
        if (gnt2) begin
            alloc_mask[id2] = 1'b1;
        end
        if (commit_valid_i && busy_q[commit_id_i]) begin
            rel_mask[commit_id_i] = 1'b1;
        end
        if (commit_valid2_i && busy_q[commit_id2_i]) begin
            rel_mask[commit_id2_i] = 1'b1;
        end
        err_set = (commit_valid_i & ~busy_q[commit_id_i])
                | (commit_valid2_i & ~busy_q[commit_id2_i])
                | (commit_valid_i & commit_valid2_i & (commit_id_i == commit_id2_i));
    end

    always_comb begin
        busy_d = (busy_q | alloc_mask) & ~rel_mask;
        free_d = free_q - popcount(alloc_mask) + popcount(rel_mask);
        ts_d   = ts_q + TS_WIDTH'(gnt1) + TS_WIDTH'(gnt2);
        err_d  = err_q | err_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            ts_q   <= '0;
            free_q <= CW'(N);
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            ts_q   <= ts_d;
            free_q <= free_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        inst1_gnt_o       = gnt1;
        inst2_gnt_o       = gnt2;
        inst1_commit_id_o = id_a;
        inst2_commit_id_o = id2;
        inst1_timestamp_o = ts_q;
        inst2_timestamp_o = ts_q + TS_WIDTH'(gnt1);
        issue_stall_o     = ~hold_i & ((inst1_req_i & ~gnt1) | (inst2_req_i & ~gnt2));
        free_cnt_o        = free_q;
        release_err_o     = err_q;
    end

    // The free counter is a shadow of the bitmap; any drift means a lost or double update.
    a_free_matches_busy: assert property (@(posedge clk) disable iff (rst)
        free_q == popcount(~busy_q));
    a_in_order: assert property (@(posedge clk) disable iff (rst)
        !(inst2_gnt_o && inst1_req_i && !inst1_gnt_o));
    a_no_overalloc: assert property (@(posedge clk) disable iff (rst)
        (alloc_mask & busy_q) == '0);

endmodule

// File: tb/tb_commit_id_alloc.sv
// Self-checking bench for commit_id_alloc: table of per-cycle vectors through a scoreboard queue,
// plus hand-written reset, release-error and asynchronous mid-stream reset sequences.
module tb_commit_id_alloc;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst1_req_i, inst2_req_i, hold_i;
    logic        commit_valid_i, commit_valid2_i;
    logic [2:0]  commit_id_i, commit_id2_i;
    logic        inst1_gnt_o, inst2_gnt_o;
    logic [2:0]  inst1_commit_id_o, inst2_commit_id_o;
    logic [31:0] inst1_timestamp_o, inst2_timestamp_o;
    logic        issue_stall_o;
    logic [3:0]  free_cnt_o;
    logic        release_err_o;

    commit_id_alloc #(.ID_WIDTH(3), .TS_WIDTH(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .inst1_req_i       (inst1_req_i),
        .inst2_req_i       (inst2_req_i),
        .hold_i            (hold_i),
        .commit_valid_i    (commit_valid_i),
        .commit_id_i       (commit_id_i),
        .commit_valid2_i   (commit_valid2_i),
        .commit_id2_i      (commit_id2_i),
        .inst1_gnt_o       (inst1_gnt_o),
        .inst2_gnt_o       (inst2_gnt_o),
        .inst1_commit_id_o (inst1_commit_id_o),
        .inst2_commit_id_o (inst2_commit_id_o),
        .inst1_timestamp_o (inst1_timestamp_o),
        .inst2_timestamp_o (inst2_timestamp_o),
        .issue_stall_o     (issue_stall_o),
        .free_cnt_o        (free_cnt_o),
        .release_err_o     (release_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r1, r2, hold, cv1;
        logic [2:0]  c1;
        logic        cv2;
        logic [2:0]  c2;
        logic        g1, g2;
        logic [2:0]  i1, i2;
        logic [31:0] t1, t2;
        logic        st;
        logic [3:0]  fc;
        logic        err;
    } vec_t;

    vec_t tbl[20];
    vec_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   vec_no = 0;

    function automatic vec_t mk(input logic r1, r2, hold, cv1, input logic [2:0] c1,
                                input logic cv2, input logic [2:0] c2,
                                input logic g1, g2, input logic [2:0] i1, i2,
                                input logic [31:0] t1, t2, input logic st,
                                input logic [3:0] fc, input logic err);
        vec_t v;
        v.r1 = r1; v.r2 = r2; v.hold = hold; v.cv1 = cv1; v.c1 = c1; v.cv2 = cv2; v.c2 = c2;
        v.g1 = g1; v.g2 = g2; v.i1 = i1; v.i2 = i2; v.t1 = t1; v.t2 = t2;
        v.st = st; v.fc = fc; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        inst1_req_i = 0; inst2_req_i = 0; hold_i = 0;
        commit_valid_i = 0; commit_id_i = 0; commit_valid2_i = 0; commit_id2_i = 0;
    endtask

    task automatic sample();
        vec_t e;
        string p;
        p = $sformatf("v%0d", vec_no);
        if (exp_q.size() == 0) begin
            chk({p, " scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({p, " gnt1"},  32'(inst1_gnt_o),       32'(e.g1));
            chk({p, " gnt2"},  32'(inst2_gnt_o),       32'(e.g2));
            chk({p, " id1"},   32'(inst1_commit_id_o), 32'(e.i1));
            chk({p, " id2"},   32'(inst2_commit_id_o), 32'(e.i2));
            chk({p, " ts1"},   inst1_timestamp_o,      e.t1);
            chk({p, " ts2"},   inst2_timestamp_o,      e.t2);
            chk({p, " stall"}, 32'(issue_stall_o),     32'(e.st));
            chk({p, " free"},  32'(free_cnt_o),        32'(e.fc));
            chk({p, " err"},   32'(release_err_o),     32'(e.err));
        end
        vec_no++;
    endtask

    // Drive on the falling edge, check combinational outputs well before the next rising edge.
    task automatic apply(input vec_t v);
        @(negedge clk);
        inst1_req_i = v.r1; inst2_req_i = v.r2; hold_i = v.hold;
        commit_valid_i = v.cv1; commit_id_i = v.c1;
        commit_valid2_i = v.cv2; commit_id2_i = v.c2;
        exp_q.push_back(v);
        #2;
        sample();
    endtask

    initial begin
        //           r1 r2 hd cv1 c1 cv2 c2 g1 g2 i1 i2 t1  t2  st fc err
        tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0,  1,  0, 8, 0);
        tbl[1]  = mk(1, 1, 0, 0, 0, 0, 0, 1, 1, 2, 3, 2,  3,  0, 6, 0);
        tbl[2]  = mk(1, 1, 0, 0, 0, 0, 0, 1, 1, 4, 5, 4,  5,  0, 4, 0);
        tbl[3]  = mk(1, 1, 0, 0, 0, 0, 0, 1, 1, 6, 7, 6,  7,  0, 2, 0);
        tbl[4]  = mk(1, 1, 0, 1, 5, 0, 0, 0, 0, 0, 0, 8,  8,  1, 0, 0); // full pool, free 5
        tbl[5]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 5, 0, 8,  9,  0, 1, 0);
        tbl[6]  = mk(0, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0, 9,  9,  0, 0, 0);
        tbl[7]  = mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 6, 0, 9,  10, 1, 1, 0); // one free, both ask
        tbl[8]  = mk(0, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0, 10, 10, 0, 0, 0);
        tbl[9]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 6, 6, 10, 10, 0, 1, 0); // lane 2 alone
        tbl[10] = mk(0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 11, 11, 0, 0, 0);
        tbl[11] = mk(1, 1, 1, 1, 2, 0, 0, 0, 0, 0, 1, 11, 11, 0, 2, 0); // hold + release 2
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11, 11, 0, 3, 0);
        tbl[13] = mk(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 11, 12, 0, 3, 0);
        tbl[14] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 13, 14, 0, 1, 0);
        tbl[15] = mk(1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 14, 14, 1, 0, 0); // release 3, not yet
        tbl[16] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 14, 15, 0, 1, 0);
        tbl[17] = mk(0, 0, 0, 1, 4, 1, 4, 0, 0, 0, 0, 15, 15, 0, 0, 0); // both ports free 4
        tbl[18] = mk(0, 0, 0, 1, 4, 0, 0, 0, 0, 4, 4, 15, 15, 0, 1, 1); // 4 already free
        tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 4, 15, 15, 0, 1, 1);

        rst = 1'b1;
        drive_idle();
        inst1_req_i = 1; inst2_req_i = 1;
        #3;
        chk("rst gnt1", 32'(inst1_gnt_o), 32'd0);
        chk("rst gnt2", 32'(inst2_gnt_o), 32'd0);
        chk("rst free", 32'(free_cnt_o), 32'd8);
        chk("rst err",  32'(release_err_o), 32'd0);
        chk("rst ts2",  inst2_timestamp_o, 32'd0);
        @(posedge clk);
        #1;
        chk("rst held free", 32'(free_cnt_o), 32'd8);
        chk("rst held gnt1", 32'(inst1_gnt_o), 32'd0);
        @(negedge clk);
        drive_idle();
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            apply(tbl[i]);
        end

        // Release of a never-allocated ID on a fresh pool.
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        apply(mk(0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0));
        apply(mk(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0, 8, 1));
        apply(mk(1, 1, 0, 0, 0, 0, 0, 1, 1, 2, 3, 2, 3, 0, 6, 1));

        // Asynchronous reset mid-cycle, requests still asserted.
        rst = 1'b1;
        #1;
        chk("async gnt1", 32'(inst1_gnt_o), 32'd0);
        chk("async gnt2", 32'(inst2_gnt_o), 32'd0);
        chk("async free", 32'(free_cnt_o), 32'd8);
        chk("async err",  32'(release_err_o), 32'd0);
        chk("async ts1",  inst1_timestamp_o, 32'd0);
        chk("async ts2",  inst2_timestamp_o, 32'd0);
        chk("async id1",  32'(inst1_commit_id_o), 32'd0);
        chk("async id2",  32'(inst2_commit_id_o), 32'd1);
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        apply(mk(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0, 8, 0));

        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
